// File: rtl/dct_pkg.sv
// Shared constants and helpers for the DCT input arbitration path.
package dct_pkg;
  localparam int DCT_N         = 4;
  localparam int DCT_BLOCK_LEN = DCT_N * DCT_N;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit scanning from ptr upward, modulo NUM_SRC.
module rr_pick #(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);
  // Scan farthest-first so the closest requester to ptr is the final write.
  always_comb begin
    logic [SRC_W-1:0] j;
    j   = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = SRC_W'((int'(ptr) + k) % NUM_SRC);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dct_block_arbiter.sv
// Block-granular round-robin arbiter feeding one DCT input stream from NUM_SRC sources.
module dct_block_arbiter
  import dct_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BLOCK_LEN  = DCT_BLOCK_LEN,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            s_valid,
  output logic [NUM_SRC-1:0]            s_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [SRC_W-1:0]              m_src,
  output logic                          m_last,
  output logic                          busy
);
  localparam int CNT_W = $clog2(BLOCK_LEN);

  state_e                             state;
  logic [SRC_W-1:0]                   grant, rr_ptr, pick_ptr, pick_idx;
  logic [CNT_W-1:0]                   beat_cnt;
  logic                               pick_any, at_last, xfer;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] data_v;

  assign data_v  = s_data;
  assign at_last = (beat_cnt == CNT_W'(BLOCK_LEN - 1));
  assign xfer    = (state == ST_GRANT) && s_valid[grant] && m_ready;
  // While granted, the finishing source sits at lowest priority for the next block.
  assign pick_ptr = (state == ST_GRANT) ? SRC_W'(mod_inc(int'(grant), NUM_SRC)) : rr_ptr;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (s_valid),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            if (at_last) begin
              rr_ptr   <= pick_ptr;
              beat_cnt <= '0;
              if (pick_any) grant <= pick_idx;
              else          state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_last  = 1'b0;
    busy    = 1'b0;
    if (state == ST_GRANT) begin
      busy           = 1'b1;
      m_valid        = s_valid[grant];
      m_data         = data_v[grant];
      m_src          = grant;
      m_last         = at_last;
      s_ready[grant] = m_ready;
    end
  end
endmodule

// File: tb/tb_dct_block_arbiter.sv
// Self-checking bench: per-cycle reference model plus directed block-order scenarios.
module tb_dct_block_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_src;
  logic            m_last;
  logic            busy;

  int base[N];
  int idx[N];
  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int lg_src[$], lg_data[$], lg_last[$], lg_cyc[$];

  for (genvar g = 0; g < N; g++) begin : g_data
    assign s_data[g*DW +: DW] = DW'(base[g] + idx[g]);
  end

  always #5 clk = ~clk;

  dct_block_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_src   (m_src),
    .m_last  (m_last),
    .busy    (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  function automatic int pick(input int from);
    for (int k = 0; k < N; k++)
      if (s_valid[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  // Reference: which source owns the stream, how many beats it has moved, who is next in line.
  task automatic monitor();
    int own, cnt, nxt;
    logic [N-1:0] e_rdy;
    own = -1; cnt = 0; nxt = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) begin
        own = -1; cnt = 0; nxt = 0;
        for (int i = 0; i < N; i++) idx[i] = 0;
        lg_src.delete(); lg_data.delete(); lg_last.delete(); lg_cyc.delete();
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data",  32'(m_data),  32'(0));
        chk("rst_m_src",   32'(m_src),   32'(0));
        chk("rst_m_last",  32'(m_last),  32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
      end else begin
        e_rdy = '0;
        if (own < 0) begin
          chk("idle_s_ready", 32'(s_ready), 32'(0));
          chk("idle_m_valid", 32'(m_valid), 32'(0));
          chk("idle_m_data",  32'(m_data),  32'(0));
          chk("idle_m_last",  32'(m_last),  32'(0));
          chk("idle_busy",    32'(busy),    32'(0));
        end else begin
          e_rdy[own] = m_ready;
          chk("gnt_s_ready", 32'(s_ready), 32'(e_rdy));
          chk("gnt_m_valid", 32'(m_valid), 32'(s_valid[own]));
          chk("gnt_m_data",  32'(m_data),  32'(s_data[own*DW +: DW]));
          chk("gnt_m_src",   32'(m_src),   32'(own));
          chk("gnt_m_last",  32'(m_last),  32'(cnt == BL - 1));
          chk("gnt_busy",    32'(busy),    32'(1));
        end
        if (m_valid && m_ready) begin
          lg_src.push_back(int'(m_src));
          lg_data.push_back(int'(m_data));
          lg_last.push_back(int'(m_last));
          lg_cyc.push_back(ncyc);
        end
        for (int i = 0; i < N; i++)
          if (s_valid[i] && s_ready[i]) idx[i]++;
        if (own < 0) begin
          own = pick(nxt);
          cnt = 0;
        end else if (s_valid[own] && m_ready) begin
          if (cnt == BL - 1) begin
            cnt = 0;
            nxt = (own + 1) % N;
            own = pick(nxt);
          end else begin
            cnt++;
          end
        end
      end
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (lg_src.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("wait_log_timeout", 32'(lg_src.size() >= n), 32'(1));
  endtask

  task automatic do_reset(input logic [N-1:0] vld, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b0; s_valid = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    s_valid = vld; m_ready = rdy; reset = 1'b1;
  endtask

  initial begin
    int lasts;
    fork monitor(); join_none
    base = '{0, 16, 32, 48};

    // Reset held with every source requesting; one cycle of arbitration after release.
    s_valid = 4'hF; m_ready = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("rsthold_s_ready", 32'(s_ready), 32'(0));
    chk("rsthold_busy",    32'(busy),    32'(0));
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); #1;
    chk("arb_latency_m_valid", 32'(m_valid), 32'(0));
    @(negedge clk); #1;
    chk("first_m_valid", 32'(m_valid), 32'(1));
    chk("first_m_src",   32'(m_src),   32'(0));
    wait_log(80, 200);
    for (int k = 0; k < 64 && k < lg_src.size(); k++) begin
      chk("rr_src",  32'(lg_src[k]),  32'(k / 16));
      chk("rr_data", 32'(lg_data[k]), 32'(k));
      chk("rr_last", 32'(lg_last[k]), 32'(k % 16 == 15));
    end
    if (lg_src.size() >= 80) begin
      chk("rr_wrap_src", 32'(lg_src[64]), 32'(0));
      chk("rr_no_gap",   32'(lg_cyc[79] - lg_cyc[0]), 32'(79));
    end

    // Single requester: one block, then it is re-granted and waits with valid low.
    base[2] = 0;
    do_reset(4'b0100, 1'b1);
    wait_log(16, 40);
    @(posedge clk); #1; s_valid = '0;
    @(negedge clk); #1;
    chk("single_regrant_busy",    32'(busy),    32'(1));
    chk("single_regrant_m_valid", 32'(m_valid), 32'(0));
    chk("single_regrant_m_src",   32'(m_src),   32'(2));
    for (int k = 0; k < 16 && k < lg_src.size(); k++) begin
      chk("single_src",  32'(lg_src[k]),  32'(2));
      chk("single_data", 32'(lg_data[k]), 32'(k));
      chk("single_last", 32'(lg_last[k]), 32'(k == 15));
    end

    // Backpressure: m_ready toggles every cycle.
    base[1] = 8'h40;
    do_reset(4'b0010, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (busy) chk("bp_s_ready", 32'(s_ready), 32'(m_ready ? 4'b0010 : 4'b0000));
      if (lg_src.size() >= 16) break;
      @(posedge clk); #1; m_ready = ~m_ready;
    end
    chk("bp_count", 32'(lg_src.size() >= 16), 32'(1));
    lasts = 0;
    for (int k = 0; k < 16 && k < lg_src.size(); k++) begin
      chk("bp_src",  32'(lg_src[k]),  32'(1));
      chk("bp_data", 32'(lg_data[k]), 32'(8'h40 + k));
      lasts += lg_last[k];
    end
    chk("bp_one_last", 32'(lasts), 32'(1));

    // Source 3 stalls for 5 cycles mid-block while source 0 waits.
    base[3] = 8'h30; base[0] = 0;
    do_reset(4'b1000, 1'b1);
    @(posedge clk); #1; s_valid = 4'b1001;
    wait_log(8, 30);
    @(posedge clk); #1; s_valid[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("gap_m_valid", 32'(m_valid), 32'(0));
      chk("gap_m_src",   32'(m_src),   32'(3));
      @(posedge clk); #1;
    end
    s_valid[3] = 1'b1;
    wait_log(17, 40);
    for (int k = 0; k < 16 && k < lg_src.size(); k++) begin
      chk("gap_blk_src",  32'(lg_src[k]),  32'(3));
      chk("gap_blk_data", 32'(lg_data[k]), 32'(8'h30 + k));
    end
    if (lg_src.size() >= 17) begin
      chk("gap_len",       32'(lg_cyc[8] - lg_cyc[7]),   32'(6));
      chk("gap_next_src",  32'(lg_src[16]),              32'(0));
      chk("gap_next_data", 32'(lg_data[16]),             32'(0));
      chk("gap_no_bubble", 32'(lg_cyc[16] - lg_cyc[15]), 32'(1));
    end

    // Asynchronous reset in the middle of a source-1 block.
    base[1] = 8'h50;
    do_reset(4'b0010, 1'b1);
    wait_log(9, 30);
    @(posedge clk); #1;
    chk("mid_beat9_data", 32'(m_data), 32'(8'h59));
    lasts = 0;
    for (int k = 0; k < lg_last.size(); k++) lasts += lg_last[k];
    chk("mid_no_last", 32'(lasts), 32'(0));
    reset = 1'b0;
    #1;
    chk("async_s_ready", 32'(s_ready), 32'(0));
    chk("async_m_valid", 32'(m_valid), 32'(0));
    chk("async_m_data",  32'(m_data),  32'(0));
    chk("async_m_last",  32'(m_last),  32'(0));
    chk("async_busy",    32'(busy),    32'(0));
    s_valid = 4'hF;
    @(negedge clk);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_idle", 32'(m_valid), 32'(0));
    @(negedge clk); #1;
    chk("post_rst_m_valid", 32'(m_valid), 32'(1));
    chk("post_rst_m_src",   32'(m_src),   32'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
